ahb_sram_bridge: RTL and testbench

AHB-Lite slave that converts bus transfers into the single-port SRAM macro's `SRAMCS`/`SRAMWEN`/`SRAMADDR`/`SRAMWDATA` controls and returns `SRAMRDATA` on `HRDATA`. It sits directly upstream of the SRAM on the AHB-Lite fabric. It always runs zero-wait-state. Writes go through a one-entry write buffer, so the SRAM address and write data are always register-driven. Reads that hit the buffer get their bytes forwarded from the buffer.

---
 rtl/ahb_sram_bridge.sv | 172 +++++++++++++++++
 tb/tb_ahb_sram_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave bridging zero-wait-state bus transfers onto a single-port SRAM macro.
// Writes pass through a one-entry buffer; reads that hit the buffer get its bytes forwarded.
module ahb_sram_bridge #(
    parameter int AW = 16
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [AW-1:0] HADDR,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [AW-3:0] SRAMADDR,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            3'd0:    mask = 4'b0001 << addr_lo;
            3'd1:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-3:0] r_addr;
    logic [3:0]    r_mask;
    logic          r_buf_valid;
    logic [AW-3:0] r_buf_addr;
    logic [3:0]    r_buf_mask;
    logic [31:0]   r_buf_data;
    logic [AW-3:0] r_last_addr;
    logic [31:0]   r_last_wdata;

    logic          w_accept;
    logic          w_drain;
    logic          w_hit;
    logic          w_sram_cs;
    logic [3:0]    w_sram_wen;
    logic [AW-3:0] w_sram_addr;
    logic [31:0]   w_sram_wdata;
    logic [31:0]   w_rdata;

    assign w_accept  = HSEL && HREADY && ((HTRANS == 2'b10) || (HTRANS == 2'b11));
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign HRDATA    = w_rdata;
    assign SRAMCS    = w_sram_cs;
    assign SRAMWEN   = w_sram_wen;
    assign SRAMADDR  = w_sram_addr;
    assign SRAMWDATA = w_sram_wdata;

    // Data-phase state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next data phase follows the type of the transfer accepted this cycle.
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
            w_state_nxt = HWRITE ? ST_WR : ST_RD;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Address-phase capture of word address and byte lanes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_addr <= {(AW-2){1'b0}};
            r_mask <= 4'b0000;
        end else if (w_accept) begin
            r_addr <= HADDR[AW-1:2];
            r_mask <= byte_mask(HSIZE, HADDR[1:0]);
        end else begin
            r_addr <= r_addr;
            r_mask <= r_mask;
        end
    end

    // SRAM port arbitration: reads win, then the buffered write, else hold the bus.
    always_comb begin
        w_sram_cs    = 1'b0;
        w_sram_wen   = 4'b0000;
        w_sram_addr  = r_last_addr;
        w_sram_wdata = r_last_wdata;
        w_drain      = 1'b0;
        if (r_state == ST_RD) begin
            w_sram_cs   = 1'b1;
            w_sram_addr = r_addr;
        end else if (r_buf_valid) begin
            w_sram_cs    = 1'b1;
            w_sram_wen   = r_buf_mask;
            w_sram_addr  = r_buf_addr;
            w_sram_wdata = r_buf_data;
            w_drain      = 1'b1;
        end else begin
            w_sram_cs    = 1'b0;
            w_sram_wen   = 4'b0000;
            w_sram_addr  = r_last_addr;
            w_sram_wdata = r_last_wdata;
        end
    end

    // Holding registers so an idle SRAM port keeps its last address and data.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_last_addr  <= {(AW-2){1'b0}};
            r_last_wdata <= 32'h0000_0000;
        end else begin
            r_last_addr  <= w_sram_addr;
            r_last_wdata <= w_sram_wdata;
        end
    end

    // Write buffer: a WR phase reloads it (even while draining), otherwise it empties on drain.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= {(AW-2){1'b0}};
            r_buf_mask  <= 4'b0000;
            r_buf_data  <= 32'h0000_0000;
        end else if (r_state == ST_WR) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= r_addr;
            r_buf_mask  <= r_mask;
            r_buf_data  <= HWDATA;
        end else if (w_drain) begin
            r_buf_valid <= 1'b0;
        end else begin
            r_buf_valid <= r_buf_valid;
        end
    end

    assign w_hit = r_buf_valid && (r_buf_addr == r_addr);

    // Read data with per-byte forwarding from a still-pending buffered write.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (r_state == ST_RD) begin
            for (int i = 0; i < 4; i++) begin
                w_rdata[8*i +: 8] = (w_hit && r_buf_mask[i]) ? r_buf_data[8*i +: 8]
                                                              : SRAMRDATA[8*i +: 8];
            end
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Self-checking bench for ahb_sram_bridge: SRAM model, transaction-level scoreboard,
// a mask vector table, directed corner sequences and randomized traffic.
module tb_ahb_sram_bridge;

    localparam int NW     = 16384;
    localparam int K_IDLE = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic        HREADY = 1'b1;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'd0;
    logic        HWRITE = 1'b0;
    logic [15:0] HADDR = 16'h0000;
    logic [31:0] HWDATA = 32'h0;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] SRAMRDATA;
    logic [13:0] SRAMADDR;
    logic [3:0]  SRAMWEN;
    logic [31:0] SRAMWDATA;
    logic        SRAMCS;

    ahb_sram_bridge #(.AW(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
        .SRAMADDR(SRAMADDR), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA), .SRAMCS(SRAMCS)
    );

    always #5 HCLK = ~HCLK;

    // SRAM array (written from the stimulus process at each rising edge) and reference copy.
    logic [31:0] mem     [0:NW-1];
    logic [31:0] ref_sram[0:NW-1];
    assign SRAMRDATA = mem[SRAMADDR];

    typedef struct { logic [13:0] a; logic [3:0] m; logic [31:0] d; } wr_t;
    wr_t pend[$];

    int          dp_kind = K_IDLE;
    logic [13:0] dp_word = 14'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic [13:0] last_addr = 14'h0;
    logic [31:0] last_wdata = 32'h0;
    logic        obs_cs;
    logic [3:0]  obs_wen;
    logic [13:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [31:0] obs_rdata;
    int          n_chk = 0;
    int          n_err = 0;

    typedef struct {
        logic [2:0]  size;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_wen;
        logic [13:0] exp_word;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_mask(input logic [2:0] size, input logic [15:0] a);
        logic [3:0] one;
        one = 4'b0001;
        if (size == 3'd0) return one << a[1:0];
        else if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        else return 4'b1111;
    endfunction

    // Memory contents as the bus sees them: committed words overlaid with pending writes.
    function automatic logic [31:0] bus_view(input logic [13:0] w);
        logic [31:0] r;
        r = ref_sram[w];
        for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].a == w) begin
                for (int b = 0; b < 4; b++) begin
                    if (pend[k].m[b]) r[8*b +: 8] = pend[k].d[8*b +: 8];
                end
            end
        end
        return r;
    endfunction

    task automatic step(input logic sel, input logic rdy, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [15:0] a, input logic [31:0] wd);
        wr_t w;
        @(negedge HCLK);
        HSEL = sel; HREADY = rdy; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a; HWDATA = wd;
        #1;
        obs_cs = SRAMCS; obs_wen = SRAMWEN; obs_addr = SRAMADDR;
        obs_wdata = SRAMWDATA; obs_rdata = HRDATA;
        chk("hreadyout", 32'(HREADYOUT), 32'h1);
        chk("hresp", 32'(HRESP), 32'h0);
        if (dp_kind == K_RD) begin
            chk("rd_hrdata", obs_rdata, bus_view(dp_word));
            chk("rd_cs", 32'(obs_cs), 32'h1);
            chk("rd_wen", 32'(obs_wen), 32'h0);
            chk("rd_addr", 32'(obs_addr), 32'(dp_word));
            last_addr = dp_word;
        end else begin
            chk("idle_hrdata", obs_rdata, 32'h0);
            if (pend.size() > 0) begin
                w = pend.pop_front();
                chk("wr_cs", 32'(obs_cs), 32'h1);
                chk("wr_wen", 32'(obs_wen), 32'(w.m));
                chk("wr_addr", 32'(obs_addr), 32'(w.a));
                chk("wr_wdata", obs_wdata, w.d);
                for (int b = 0; b < 4; b++) begin
                    if (w.m[b]) ref_sram[w.a][8*b +: 8] = w.d[8*b +: 8];
                end
                last_addr = w.a;
                last_wdata = w.d;
            end else begin
                chk("nop_cs", 32'(obs_cs), 32'h0);
                chk("nop_wen", 32'(obs_wen), 32'h0);
                chk("nop_addr_hold", 32'(obs_addr), 32'(last_addr));
                chk("nop_wdata_hold", obs_wdata, last_wdata);
            end
        end
        if (dp_kind == K_WR) pend.push_back('{a: dp_word, m: dp_mask, d: wd});
        if (sel && rdy && tr[1]) begin
            dp_kind = wr ? K_WR : K_RD;
            dp_word = a[15:2];
            dp_mask = exp_mask(sz, a);
        end else begin
            dp_kind = K_IDLE;
        end
        @(posedge HCLK);
        if (obs_cs) begin
            for (int b = 0; b < 4; b++) begin
                if (obs_wen[b]) mem[obs_addr][8*b +: 8] = obs_wdata[8*b +: 8];
            end
        end
    endtask

    task automatic bus(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [15:0] a, input logic [31:0] wd);
        step(1'b1, 1'b1, tr, wr, sz, a, wd);
    endtask

    task automatic idle(input logic [31:0] wd);
        step(1'b1, 1'b1, 2'b00, 1'b0, 3'd0, 16'h0, wd);
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        #1;
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_cs", 32'(SRAMCS), 32'h0);
        chk("rst_wen", 32'(SRAMWEN), 32'h0);
        chk("rst_addr", 32'(SRAMADDR), 32'h0);
        chk("rst_wdata", SRAMWDATA, 32'h0);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("rst_hresp", 32'(HRESP), 32'h0);
        pend.delete();
        dp_kind = K_IDLE;
        last_addr = 14'h0;
        last_wdata = 32'h0;
        @(posedge HCLK);
        #2;
        HRESET = 1'b0;
    endtask

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    initial begin
        vt[0] = '{3'd0, 16'h0030, 32'h0000_00A1, 4'b0001, 14'h00C};
        vt[1] = '{3'd0, 16'h0031, 32'h0000_A200, 4'b0010, 14'h00C};
        vt[2] = '{3'd0, 16'h0033, 32'hA300_0000, 4'b1000, 14'h00C};
        vt[3] = '{3'd1, 16'h0032, 32'hB1B1_0000, 4'b1100, 14'h00C};
        vt[4] = '{3'd1, 16'h0034, 32'h0000_B2B2, 4'b0011, 14'h00D};
        vt[5] = '{3'd1, 16'h0037, 32'hB3B3_0000, 4'b1100, 14'h00D};
        vt[6] = '{3'd2, 16'h0038, 32'hC0C1_C2C3, 4'b1111, 14'h00E};
        vt[7] = '{3'd3, 16'h003C, 32'hD0D1_D2D3, 4'b1111, 14'h00F};
        vt[8] = '{3'd7, 16'h0041, 32'hE0E1_E2E3, 4'b1111, 14'h010};

        for (int i = 0; i < NW; i++) begin
            mem[i] = (32'(i) * 32'h0100_0193) ^ 32'hA5A5_A5A5;
            ref_sram[i] = mem[i];
        end

        do_reset();

        // Mask table: write, one cycle data phase, commit observed next cycle, then read back.
        for (int i = 0; i < 9; i++) begin
            bus(NS, 1'b1, vt[i].size, vt[i].addr, 32'h0);
            idle(vt[i].wdata);
            idle(32'h0);
            chk("tbl_wen", 32'(obs_wen), 32'(vt[i].exp_wen));
            chk("tbl_addr", 32'(obs_addr), 32'(vt[i].exp_word));
            chk("tbl_wdata", obs_wdata, vt[i].wdata);
            bus(NS, 1'b0, 3'd2, vt[i].addr, 32'h0);
            idle(32'h0);
        end

        // Reset while the buffer holds a write.
        bus(NS, 1'b1, 3'd2, 16'h0010, 32'h0); idle(32'h0102_0304); idle(32'h0);
        bus(NS, 1'b1, 3'd2, 16'h0010, 32'h0); idle(32'hDEAD_BEEF);
        do_reset();
        chk("rst_discard_mem", mem[4], 32'h0102_0304);
        bus(NS, 1'b0, 3'd2, 16'h0010, 32'h0); idle(32'h0);
        chk("rst_discard_read", obs_rdata, 32'h0102_0304);

        // Word write, IDLE, read.
        bus(NS, 1'b1, 3'd2, 16'h0020, 32'h0); idle(32'h1234_5678);
        bus(NS, 1'b0, 3'd2, 16'h0020, 32'h0);
        chk("wir_cs", 32'(obs_cs), 32'h1);
        chk("wir_wen", 32'(obs_wen), 32'hF);
        chk("wir_addr", 32'(obs_addr), 32'h8);
        idle(32'h0);
        chk("wir_read", obs_rdata, 32'h1234_5678);

        // Back-to-back write/read to the same word: forwarding, commit after the read.
        bus(NS, 1'b1, 3'd2, 16'h0040, 32'h0);
        bus(NS, 1'b0, 3'd2, 16'h0040, 32'hCAFE_F00D);
        idle(32'h0);
        chk("b2b_read", obs_rdata, 32'hCAFE_F00D);
        chk("b2b_nowen", 32'(obs_wen), 32'h0);
        idle(32'h0);
        chk("b2b_commit_wen", 32'(obs_wen), 32'hF);
        chk("b2b_commit_addr", 32'(obs_addr), 32'h10);
        chk("b2b_commit_data", obs_wdata, 32'hCAFE_F00D);

        // Byte then halfword into a zeroed word.
        bus(NS, 1'b1, 3'd2, 16'h0030, 32'h0); idle(32'h0); idle(32'h0);
        bus(NS, 1'b1, 3'd0, 16'h0031, 32'h0);
        bus(NS, 1'b1, 3'd1, 16'h0032, 32'h0000_AA00);
        idle(32'hBBBB_0000);
        chk("bh_wen_byte", 32'(obs_wen), 32'h2);
        bus(NS, 1'b0, 3'd2, 16'h0030, 32'h0);
        chk("bh_wen_half", 32'(obs_wen), 32'hC);
        idle(32'h0);
        chk("bh_read", obs_rdata, 32'hBBBB_AA00);

        // Partial forwarding of a single byte.
        bus(NS, 1'b1, 3'd2, 16'h0050, 32'h0); idle(32'h1122_3344); idle(32'h0);
        bus(NS, 1'b1, 3'd0, 16'h0050, 32'h0);
        bus(NS, 1'b0, 3'd2, 16'h0050, 32'h0000_0099);
        idle(32'h0);
        chk("pfwd_read", obs_rdata, 32'h1122_3399);
        idle(32'h0);

        // Read burst starves the buffer until the first non-read cycle.
        bus(NS, 1'b1, 3'd2, 16'h0060, 32'h0);
        bus(NS, 1'b0, 3'd2, 16'h0064, 32'h600D_0060);
        bus(SQ, 1'b0, 3'd2, 16'h0068, 32'h0);
        chk("burst_wen0", 32'(obs_wen), 32'h0);
        bus(SQ, 1'b0, 3'd2, 16'h006C, 32'h0);
        chk("burst_wen1", 32'(obs_wen), 32'h0);
        bus(SQ, 1'b0, 3'd2, 16'h0070, 32'h0);
        chk("burst_wen2", 32'(obs_wen), 32'h0);
        idle(32'h0);
        chk("burst_wen3", 32'(obs_wen), 32'h0);
        idle(32'h0);
        chk("burst_commit_wen", 32'(obs_wen), 32'hF);
        chk("burst_commit_addr", 32'(obs_addr), 32'h18);
        chk("burst_commit_data", obs_wdata, 32'h600D_0060);

        // Randomized traffic over a small window so buffer hits are frequent.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 8) != 0, ($urandom % 8) != 0, 2'($urandom % 4), 1'($urandom % 2),
                 3'($urandom % 8), 16'($urandom % 64), $urandom);
        end
        idle(32'h0); idle(32'h0); idle(32'h0);
        for (int i = 0; i < 32; i++) begin
            chk("final_mem", mem[i], ref_sram[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
